// File: rtl/wb_write_arbiter.sv
// -----------------------------------------------------------------------------
// wb_write_arbiter
//
// Owns the single register-file write port. It merges two result sources:
// the in-order pipeline writeback (ALU/load), which can never stall, and the
// multi-cycle MUL/DIV unit, which uses a valid/ready handshake. MUL/DIV results
// that lose arbitration wait in a small in-order FIFO. All outputs are
// registered on the rising edge, so they are stable for the register file's
// falling-edge write.
//
// Parameters:
//   DEPTH  MUL/DIV result FIFO entries (power of two, >= 2)
//   AW     register address width
//   DW     data width
//
// Ports:
//   CLK          clock, all state updates on the rising edge
//   RESET        asynchronous active-low reset
//   ALU_WB_EN    pipeline writeback request this cycle
//   ALU_WB_ADDR  pipeline destination register
//   ALU_WB_DATA  pipeline result
//   MD_VALID     MUL/DIV result valid
//   MD_ADDR      MUL/DIV destination register
//   MD_DATA      MUL/DIV result
//   MD_READY     arbiter can accept a MUL/DIV result (COUNT < DEPTH)
//   WRITE_EN     register-file write enable
//   WRITE_ADDR   register-file write address
//   WRITE_DATA   register-file write data
//   PENDING      FIFO non-empty (used by the hazard unit for WAW stalls)
//   COUNT        FIFO occupancy, 0..DEPTH
// -----------------------------------------------------------------------------
module wb_write_arbiter #(
  parameter int DEPTH = 4,
  parameter int AW    = 5,
  parameter int DW    = 32
) (
  input  logic                   CLK,
  input  logic                   RESET,
  input  logic                   ALU_WB_EN,
  input  logic [AW-1:0]          ALU_WB_ADDR,
  input  logic [DW-1:0]          ALU_WB_DATA,
  input  logic                   MD_VALID,
  input  logic [AW-1:0]          MD_ADDR,
  input  logic [DW-1:0]          MD_DATA,
  output logic                   MD_READY,
  output logic                   WRITE_EN,
  output logic [AW-1:0]          WRITE_ADDR,
  output logic [DW-1:0]          WRITE_DATA,
  output logic                   PENDING,
  output logic [$clog2(DEPTH):0] COUNT
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  // FIFO storage; contents need no reset because only pushed slots are read
  logic [AW-1:0] addr_mem [DEPTH];
  logic [DW-1:0] data_mem [DEPTH];

  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;

  logic alu_req;
  logic md_accept;
  logic md_live;
  logic fifo_nonempty;
  logic pop;
  logic push;
  logic bypass;

  // Ready depends on registered occupancy only, never on this cycle's inputs
  assign MD_READY = (COUNT < FULL);
  assign PENDING  = (COUNT != '0);

  always_comb begin
    alu_req       = 1'b0;
    md_accept     = 1'b0;
    md_live       = 1'b0;
    fifo_nonempty = 1'b0;
    pop           = 1'b0;
    push          = 1'b0;
    bypass        = 1'b0;

    // A write to x0 is no request at all, leaving the port free
    alu_req       = ALU_WB_EN && (ALU_WB_ADDR != '0);
    md_accept     = MD_VALID && MD_READY;
    // Accepted x0 results are consumed and silently dropped
    md_live       = md_accept && (MD_ADDR != '0);
    fifo_nonempty = (COUNT != '0);

    pop    = !alu_req && fifo_nonempty;
    bypass = !alu_req && !fifo_nonempty && md_live;
    // When buffered entries exist the new result must queue behind them
    push   = md_live && (alu_req || fifo_nonempty);
  end

  always_ff @(posedge CLK) begin
    if (push) begin
      addr_mem[wr_ptr] <= MD_ADDR;
      data_mem[wr_ptr] <= MD_DATA;
    end
  end

  // Pointers are PW bits wide, so the increment wraps modulo DEPTH
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      COUNT  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      unique case ({push, pop})
        2'b10:   COUNT <= COUNT + 1'b1;
        2'b01:   COUNT <= COUNT - 1'b1;
        default: COUNT <= COUNT;
      endcase
    end
  end

  // Idle cycles drop WRITE_EN but keep the last address/data on the bus
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      WRITE_EN   <= 1'b0;
      WRITE_ADDR <= '0;
      WRITE_DATA <= '0;
    end else if (alu_req) begin
      WRITE_EN   <= 1'b1;
      WRITE_ADDR <= ALU_WB_ADDR;
      WRITE_DATA <= ALU_WB_DATA;
    end else if (pop) begin
      WRITE_EN   <= 1'b1;
      WRITE_ADDR <= addr_mem[rd_ptr];
      WRITE_DATA <= data_mem[rd_ptr];
    end else if (bypass) begin
      WRITE_EN   <= 1'b1;
      WRITE_ADDR <= MD_ADDR;
      WRITE_DATA <= MD_DATA;
    end else begin
      WRITE_EN   <= 1'b0;
    end
  end

endmodule

// File: tb/tb_wb_write_arbiter.sv
// -----------------------------------------------------------------------------
// tb_wb_write_arbiter
//
// Self-checking bench for wb_write_arbiter. A reference model keeps every
// accepted non-x0 MUL/DIV result in a queue in acceptance order; on each edge
// an ALU request to a non-zero register takes the port, otherwise the oldest
// queued MUL/DIV result retires. Directed scenarios are followed by a random
// phase in which the MUL/DIV source holds its result until accepted.
// -----------------------------------------------------------------------------
module tb_wb_write_arbiter;

  localparam int DEPTH = 4;
  localparam int AW    = 5;
  localparam int DW    = 32;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic          CLK;
  logic          RESET;
  logic          ALU_WB_EN;
  logic [AW-1:0] ALU_WB_ADDR;
  logic [DW-1:0] ALU_WB_DATA;
  logic          MD_VALID;
  logic [AW-1:0] MD_ADDR;
  logic [DW-1:0] MD_DATA;
  logic          MD_READY;
  logic          WRITE_EN;
  logic [AW-1:0] WRITE_ADDR;
  logic [DW-1:0] WRITE_DATA;
  logic          PENDING;
  logic [CW-1:0] COUNT;

  wb_write_arbiter #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
    .CLK         (CLK),
    .RESET       (RESET),
    .ALU_WB_EN   (ALU_WB_EN),
    .ALU_WB_ADDR (ALU_WB_ADDR),
    .ALU_WB_DATA (ALU_WB_DATA),
    .MD_VALID    (MD_VALID),
    .MD_ADDR     (MD_ADDR),
    .MD_DATA     (MD_DATA),
    .MD_READY    (MD_READY),
    .WRITE_EN    (WRITE_EN),
    .WRITE_ADDR  (WRITE_ADDR),
    .WRITE_DATA  (WRITE_DATA),
    .PENDING     (PENDING),
    .COUNT       (COUNT)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int unsigned total = 0;
  int unsigned bad   = 0;

  // Reference state: pending MUL/DIV results and the last value on the bus
  logic [AW+DW-1:0] mq[$];
  logic [AW-1:0]    last_addr;
  logic [DW-1:0]    last_data;
  logic             last_acc;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_alu(input logic en, input logic [AW-1:0] a, input logic [DW-1:0] d);
    ALU_WB_EN = en; ALU_WB_ADDR = a; ALU_WB_DATA = d;
  endtask

  task automatic set_md(input logic v, input logic [AW-1:0] a, input logic [DW-1:0] d);
    MD_VALID = v; MD_ADDR = a; MD_DATA = d;
  endtask

  // Called 1 time unit after a rising edge with inputs already applied;
  // predicts the next edge, advances past it and compares.
  task automatic cycle(input string tag);
    logic             ready_m;
    logic             exp_we;
    logic [AW+DW-1:0] head;
    ready_m = (mq.size() < DEPTH);
    check({tag, ".ready"}, 32'(MD_READY), 32'(ready_m));
    last_acc = MD_VALID && ready_m;
    if (last_acc && MD_ADDR != '0) mq.push_back({MD_ADDR, MD_DATA});
    exp_we = 1'b0;
    if (ALU_WB_EN && ALU_WB_ADDR != '0) begin
      exp_we = 1'b1; last_addr = ALU_WB_ADDR; last_data = ALU_WB_DATA;
    end else if (mq.size() != 0) begin
      head = mq.pop_front();
      exp_we = 1'b1; last_addr = head[AW+DW-1:DW]; last_data = head[DW-1:0];
    end
    @(posedge CLK);
    #1;
    check({tag, ".we"},    32'(WRITE_EN),   32'(exp_we));
    check({tag, ".addr"},  32'(WRITE_ADDR), 32'(last_addr));
    check({tag, ".data"},  WRITE_DATA,      last_data);
    check({tag, ".count"}, 32'(COUNT),      32'(mq.size()));
    check({tag, ".pend"},  32'(PENDING),    32'(mq.size() != 0));
  endtask

  // Pulls reset low mid-cycle, checks the asynchronous clear, holds it across
  // one rising edge and releases mid-cycle.
  task automatic pulse_reset(input string tag);
    #2;
    RESET = 1'b0;
    #1;
    check({tag, ".we"},    32'(WRITE_EN),   32'd0);
    check({tag, ".addr"},  32'(WRITE_ADDR), 32'd0);
    check({tag, ".data"},  WRITE_DATA,      32'd0);
    check({tag, ".count"}, 32'(COUNT),      32'd0);
    check({tag, ".pend"},  32'(PENDING),    32'd0);
    check({tag, ".ready"}, 32'(MD_READY),   32'd1);
    mq.delete();
    last_addr = '0;
    last_data = '0;
    set_alu(1'b0, '0, '0);
    set_md(1'b0, '0, '0);
    @(posedge CLK);
    #2;
    RESET = 1'b1;
    @(posedge CLK);
    #1;
    check({tag, ".post_we"}, 32'(WRITE_EN), 32'd0);
  endtask

  initial begin
    RESET = 1'b1;
    set_alu(1'b0, '0, '0);
    set_md(1'b0, '0, '0);
    last_addr = '0;
    last_data = '0;
    last_acc  = 1'b0;
    @(posedge CLK);
    #1;
    pulse_reset("rst");

    // ALU path, then an idle cycle that must hold addr/data
    set_alu(1'b1, 5'd5, 32'hDEADBEEF);
    cycle("alu");
    check("alu.addr5", 32'(WRITE_ADDR), 32'd5);
    check("alu.dbeef", WRITE_DATA, 32'hDEADBEEF);
    set_alu(1'b0, '0, '0);
    cycle("idle");
    check("idle.hold", WRITE_DATA, 32'hDEADBEEF);

    // Bypass with empty FIFO
    set_md(1'b1, 5'd7, 32'h12);
    cycle("byp");
    check("byp.addr7", 32'(WRITE_ADDR), 32'd7);
    check("byp.cnt0", 32'(COUNT), 32'd0);
    set_md(1'b0, '0, '0);
    cycle("byp_idle");

    // Contention: ALU x10..x15 while MD offers x1..x5, holding until taken
    for (int i = 0; i < 5; i++) begin
      set_md(1'b1, 5'(i + 1), 32'h100 + 32'(i));
      do begin
        if (total < 200 && ALU_WB_ADDR < 5'd15 && (ALU_WB_EN || i == 0))
          set_alu(1'b1, (ALU_WB_EN ? ALU_WB_ADDR + 5'd1 : 5'd10), 32'hA000 + 32'(i));
        else
          set_alu(1'b0, '0, '0);
        cycle("cont");
        if (ALU_WB_ADDR == 5'd13 && ALU_WB_EN) begin
          check("cont.full", 32'(COUNT), 32'(DEPTH));
          check("cont.nrdy", 32'(MD_READY), 32'd0);
        end
      end while (!last_acc);
    end
    set_md(1'b0, '0, '0);
    set_alu(1'b0, '0, '0);
    for (int i = 0; i < 5; i++) cycle("drain");
    check("drain.x5", 32'(WRITE_ADDR), 32'd5);
    check("drain.cnt", 32'(COUNT), 32'd0);

    // x0 handling: ALU to x0 lets the buffered x3 retire
    set_alu(1'b1, 5'd10, 32'h55);
    set_md(1'b1, 5'd3, 32'h33);
    cycle("x0a");
    check("x0a.cnt1", 32'(COUNT), 32'd1);
    set_md(1'b0, '0, '0);
    set_alu(1'b1, 5'd0, 32'hFFFF);
    cycle("x0b");
    check("x0b.addr3", 32'(WRITE_ADDR), 32'd3);
    set_alu(1'b0, '0, '0);
    set_md(1'b1, 5'd0, 32'h99);
    cycle("x0md");
    check("x0md.we", 32'(WRITE_EN), 32'd0);
    set_md(1'b0, '0, '0);

    // Reset mid-drain with three buffered results
    for (int i = 0; i < 3; i++) begin
      set_alu(1'b1, 5'(20 + i), 32'(i));
      set_md(1'b1, 5'(1 + i), 32'h700 + 32'(i));
      cycle("fill");
    end
    set_alu(1'b0, '0, '0);
    set_md(1'b0, '0, '0);
    check("fill.cnt3", 32'(COUNT), 32'd3);
    pulse_reset("rst2");
    for (int i = 0; i < 4; i++) cycle("post_rst");

    // Random phase: first ALU-heavy (fills FIFO), then ALU-light (drains)
    for (int n = 0; n < 400; n++) begin
      if (n < 200) set_alu(($urandom % 4) != 0, 5'($urandom % 32), $urandom);
      else         set_alu(($urandom % 4) == 0, 5'($urandom % 32), $urandom);
      if (!(MD_VALID && !last_acc))
        set_md(($urandom % 5) < 3, 5'($urandom % 32), $urandom);
      cycle("rnd");
    end
    set_alu(1'b0, '0, '0);
    set_md(1'b0, '0, '0);
    for (int i = 0; i < DEPTH + 2; i++) cycle("final");
    check("final.cnt", 32'(COUNT), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/wb_write_arbiter.md
Name: wb_write_arbiter

Overview:
- Writer side of the 32x32 register file: owns the single register-file write port (WRITE_EN/WRITE_ADDR/WRITE_DATA).
- Merges two result sources:
  - the in-order pipeline writeback (ALU/load), which cannot stall;
  - the multi-cycle MUL/DIV unit, which uses a valid/ready handshake.
- MUL/DIV results that lose arbitration are held in a small FIFO.
- Outputs are registered on posedge CLK, so they are stable at the register file's negedge write.

Parameters:
- DEPTH, 4, MUL/DIV result FIFO entries; power of two, >= 2.
- AW, 5, register address width.
- DW, 32, data width.

Ports:
- CLK  in  1  clock; all state updates on posedge.
- RESET  in  1  asynchronous, active-low reset.
- ALU_WB_EN  in  1  pipeline writeback request this cycle.
- ALU_WB_ADDR  in  AW  pipeline destination register.
- ALU_WB_DATA  in  DW  pipeline result.
- MD_VALID  in  1  MUL/DIV result valid.
- MD_ADDR  in  AW  MUL/DIV destination register.
- MD_DATA  in  DW  MUL/DIV result.
- MD_READY  out  1  arbiter can accept a MUL/DIV result.
- WRITE_EN  out  1  register-file write enable.
- WRITE_ADDR  out  AW  register-file write address.
- WRITE_DATA  out  DW  register-file write data.
- PENDING  out  1  FIFO non-empty.
- COUNT  out  clog2(DEPTH)+1  FIFO occupancy.

Behaviour:
- Reset (RESET low, asynchronous):
  - WRITE_EN=0, WRITE_ADDR=0, WRITE_DATA=0.
  - FIFO read/write pointers=0, COUNT=0, PENDING=0.
  - Any buffered entries are discarded; no write is issued for them after RESET rises.
- MD_READY = (COUNT < DEPTH):
  - derived from registered COUNT only; no combinational path from MD_VALID or ALU inputs;
  - MD_READY=1 out of reset.
- MUL/DIV accept: MD_VALID & MD_READY at a posedge.
  - An accepted result with MD_ADDR==0 is consumed and dropped: no FIFO push, no write.
- Port selection at each posedge, in priority order:
  1. ALU_WB_EN=1 and ALU_WB_ADDR!=0: WRITE_EN=1, WRITE_ADDR/WRITE_DATA = ALU inputs.
  2. Otherwise, if FIFO non-empty: pop head; WRITE_EN=1 with the head's addr/data.
  3. Otherwise, if a non-zero-address MD result is accepted this cycle: bypass it directly to the write port (no FIFO push). MD latency is 1 cycle.
  4. Otherwise: WRITE_EN=0; WRITE_ADDR/WRITE_DATA hold their previous values.
- ALU_WB_EN=1 with ALU_WB_ADDR==0 is treated as no request; the port is free for rules 2/3.
- Push:
  - An accepted non-zero MD result is pushed when rule 1 wins, or when rule 2 wins (FIFO non-empty preserves order).
  - A simultaneous push and pop leaves COUNT unchanged; the pushed entry goes behind the existing entries.
- FIFO ordering is strict: entries retire in acceptance order.
  - Pointers wrap modulo DEPTH.
  - COUNT spans 0..DEPTH; PENDING = (COUNT!=0).
- Full condition (COUNT==DEPTH): MD_READY=0.
  - An MD_VALID held high is not accepted.
  - The MUL/DIV unit must hold MD_ADDR/MD_DATA stable until accepted.
- ALU write latency: 1 cycle (posedge after request); ALU is never delayed or dropped.
- WAW ordering between an in-flight MUL/DIV result and a younger ALU write to the same rd is not resolved here. The hazard unit stalls such sequences; PENDING is exported for that purpose.
- No X propagation: WRITE_ADDR/WRITE_DATA are always driven from reset or captured values.

Test Plan:
- Reset: assert RESET=0 mid-cycle -> immediately WRITE_EN=0, WRITE_ADDR=0, WRITE_DATA=0, COUNT=0, PENDING=0, MD_READY=1.
- ALU path: ALU_WB_EN=1, addr 5, data 0xDEADBEEF -> next posedge WRITE_EN=1, WRITE_ADDR=5, WRITE_DATA=0xDEADBEEF; the following idle cycle gives WRITE_EN=0 with addr/data held.
- Bypass: ALU idle, FIFO empty, MD_VALID=1 addr 7 data 0x12 -> next posedge WRITE_EN=1, addr 7, data 0x12, COUNT stays 0.
- Contention/full:
  - ALU writes x10..x15 on 6 consecutive cycles while MD presents x1..x5 back-to-back.
  - x1..x4 accepted, COUNT=4, MD_READY=0, x5 held.
  - ALU stops -> writes x1, x2, x3, x4 on consecutive cycles, then x5; COUNT returns to 0.
- x0 handling:
  - With COUNT=1 (x3), ALU_WB_EN=1 addr 0 -> x3 pops and is written that cycle.
  - Separately, MD addr 0 accepted -> no write, COUNT unchanged.
- Reset mid-drain: COUNT=3, PENDING=1, pull RESET low for one cycle -> COUNT=0, WRITE_EN=0; no writes of the discarded entries after release.
